// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//
// AHB-side slave that turns each selected bus transfer into one APB
// SETUP/ACCESS transaction. The APB region starting at BASE_ADDR is split
// into NUM_PSLV 4 KB slots, each with its own PSEL/PREADY/PSLVERR/PRDATA.
// Addresses outside the populated slots are answered with a decode error
// without starting an APB cycle. A slave that never raises PREADY is
// abandoned after TIMEOUT_CYCLES ACCESS cycles. Every error response returns
// ERR_DATA on HRDATA and pulses bus_err for the response cycle.
//
// Ports
//   HCLK, HRESET         clock, asynchronous active-high reset
//   HSEL, HADDR, HWRITE,  bus request (address phase), write data and byte
//   HBE, HWDATA           enables valid in the same cycle as HSEL
//   HRDATA, HREADY        response to the bus; HRDATA held between responses
//   PADDR, PSEL, PENABLE, APB master side; PSEL is one-hot per slot
//   PWRITE, PSTRB, PWDATA
//   PRDATA, PREADY,       per-slot APB responses; slot i read data sits in
//   PSLVERR               PRDATA[32i+31:32i]
//   bus_err               one-cycle pulse during an error response
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000D000,
    parameter int unsigned           NUM_PSLV       = 4,
    parameter int unsigned           TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [ADDR_WIDTH-1:0]    HADDR,
    input  logic                     HWRITE,
    input  logic [3:0]               HBE,
    input  logic [31:0]              HWDATA,
    output logic [31:0]              HRDATA,
    output logic                     HREADY,
    output logic [ADDR_WIDTH-1:0]    PADDR,
    output logic [NUM_PSLV-1:0]      PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [3:0]               PSTRB,
    output logic [31:0]              PWDATA,
    input  logic [NUM_PSLV*32-1:0]   PRDATA,
    input  logic [NUM_PSLV-1:0]      PREADY,
    input  logic [NUM_PSLV-1:0]      PSLVERR,
    output logic                     bus_err
);

    localparam int unsigned SLOT_W = ADDR_WIDTH - 12;
    localparam int unsigned IDX_W  = (NUM_PSLV > 1) ? $clog2(NUM_PSLV) : 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SLOT_W-1:0] NUM_SLOTS = SLOT_W'(NUM_PSLV);
    // Compared before the increment, so the counter reaches TIMEOUT_CYCLES
    // on the same edge that leaves ACCESS.
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] tmo_cnt;

    // Address-phase decode of the incoming request.
    logic [ADDR_WIDTH-1:0] addr_off;
    logic [SLOT_W-1:0]     slot_full;
    logic [IDX_W-1:0]      slot_idx;
    logic                  slot_ok;
    logic [NUM_PSLV-1:0]   slot_onehot;

    // Response of the slot owning the transfer in flight.
    logic                  sel_ready;
    logic                  sel_err;
    logic [31:0]           sel_rdata;

    always_comb begin
        // NOTE: every always_comb output gets a value before any conditional
        // logic, so no path can leave it unassigned and infer a latch.
        addr_off    = HADDR - BASE_ADDR;
        slot_full   = addr_off[ADDR_WIDTH-1:12];
        slot_idx    = slot_full[IDX_W-1:0];
        // Addresses below the base wrap to a huge offset, but are rejected
        // explicitly rather than relying on that wrap.
        slot_ok     = (HADDR >= BASE_ADDR) && (slot_full < NUM_SLOTS);
        slot_onehot = '0;
        slot_onehot[slot_idx] = 1'b1;
    end

    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[{idx_q, 5'b0} +: 32];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // Asynchronous: PSEL/PENABLE drop the moment reset is asserted,
            // abandoning any transfer in flight.
            state   <= IDLE;
            HRDATA  <= '0;
            HREADY  <= 1'b1;
            PADDR   <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PSTRB   <= '0;
            PWDATA  <= '0;
            bus_err <= 1'b0;
            idx_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            bus_err <= 1'b0;
            case (state)
                // RESP accepts a new request exactly like IDLE, which gives
                // back-to-back transfers with no idle cycle in between.
                IDLE, RESP: begin
                    HREADY  <= 1'b1;
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                    if (HSEL) begin
                        if (slot_ok) begin
                            state  <= SETUP;
                            HREADY <= 1'b0;
                            PADDR  <= HADDR;
                            PWRITE <= HWRITE;
                            PWDATA <= HWDATA;
                            PSTRB  <= HWRITE ? HBE : 4'b0000;
                            idx_q  <= slot_idx;
                            PSEL   <= slot_onehot;
                        end else begin
                            state   <= RESP;
                            HRDATA  <= ERR_DATA;
                            bus_err <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                    tmo_cnt <= '0;
                end

                ACCESS: begin
                    // PREADY is tested first so a completion in the timeout
                    // cycle is still a normal response.
                    if (sel_ready) begin
                        state   <= RESP;
                        HREADY  <= 1'b1;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (sel_err) begin
                            HRDATA  <= ERR_DATA;
                            bus_err <= 1'b1;
                        end else begin
                            HRDATA <= PWRITE ? 32'h0 : sel_rdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        if (tmo_cnt == TMO_LAST) begin
                            state   <= RESP;
                            HREADY  <= 1'b1;
                            PSEL    <= '0;
                            PENABLE <= 1'b0;
                            HRDATA  <= ERR_DATA;
                            bus_err <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
//
// Directed steps followed by randomized transfers. Expected responses come
// from a transfer-level model: a request maps to a slot by address
// arithmetic, takes min(waits+1, TMO) ACCESS cycles, and ends in an error
// response when the slot is invalid, the slave times out or the slave flags
// PSLVERR. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h4000D000;
    localparam int          NS   = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic            HSEL;
    logic [AW-1:0]   HADDR;
    logic            HWRITE;
    logic [3:0]      HBE;
    logic [31:0]     HWDATA;
    logic [31:0]     HRDATA;
    logic            HREADY;
    logic [AW-1:0]   PADDR;
    logic [NS-1:0]   PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [3:0]      PSTRB;
    logic [31:0]     PWDATA;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0]   PREADY;
    logic [NS-1:0]   PSLVERR;
    logic            bus_err;

    ahb_apb_bridge #(
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE),
        .NUM_PSLV       (NS),
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (ERRD)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .HSEL    (HSEL),
        .HADDR   (HADDR),
        .HWRITE  (HWRITE),
        .HBE     (HBE),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PSTRB   (PSTRB),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .bus_err (bus_err)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    // Model state: the request last presented and the HRDATA the bus holds.
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_write;
    logic [3:0]  cur_be;
    logic [31:0] last_hrdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for the coming clock edge.
    task automatic drive_req(input logic [31:0] addr, input logic wr,
                             input logic [3:0] be, input logic [31:0] wdata);
        cur_addr  = addr;
        cur_write = wr;
        cur_be    = be;
        cur_wdata = wdata;
        HSEL   = 1'b1;
        HADDR  = addr;
        HWRITE = wr;
        HBE    = be;
        HWDATA = wdata;
    endtask

    // Random junk on the request lines while the bridge is busy.
    task automatic scramble_req();
        HSEL   = 1'($urandom);
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HBE    = 4'($urandom);
        HWDATA = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        HSEL = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            check("idle_hready",  HREADY,  1);
            check("idle_psel",    PSEL,    0);
            check("idle_penable", PENABLE, 0);
            check("idle_buserr",  bus_err, 0);
            check("idle_hrdata",  HRDATA,  last_hrdata);
        end
    endtask

    // Run the request presented by drive_req through to its response cycle.
    // Returns at the falling edge of the response cycle, so the caller may
    // present a back-to-back request immediately.
    task automatic finish_xfer(input int waits, input bit slverr, input logic [32:0] rd_fix);
        bit            valid;
        bit            err;
        int            slot;
        int            acc;
        logic [NS-1:0] onehot;
        logic [NS-1:0] rdy;
        logic [NS-1:0] serr;
        logic [3:0]    exp_strb;
        logic [31:0]   exp_rd;

        valid    = (cur_addr >= BASE) && (((cur_addr - BASE) >> 12) < 32'(NS));
        slot     = valid ? int'((cur_addr - BASE) >> 12) : 0;
        onehot   = '0;
        onehot[slot] = 1'b1;
        exp_strb = cur_write ? cur_be : 4'b0000;
        acc      = (waits < TMO) ? waits + 1 : TMO;
        err      = !valid || (waits >= TMO) || slverr;
        exp_rd   = 32'h0;

        @(posedge HCLK);
        @(negedge HCLK);
        if (valid) begin
            check("setup_psel",    PSEL,    onehot);
            check("setup_penable", PENABLE, 0);
            check("setup_hready",  HREADY,  0);
            check("setup_paddr",   PADDR,   cur_addr);
            check("setup_pwrite",  PWRITE,  cur_write);
            check("setup_pstrb",   PSTRB,   exp_strb);
            check("setup_pwdata",  PWDATA,  cur_wdata);
            check("setup_hrdata",  HRDATA,  last_hrdata);
            scramble_req();
            for (int k = 0; k < acc; k++) begin
                @(posedge HCLK);
                @(negedge HCLK);
                check("acc_psel",    PSEL,    onehot);
                check("acc_penable", PENABLE, 1);
                check("acc_hready",  HREADY,  0);
                check("acc_paddr",   PADDR,   cur_addr);
                check("acc_pwrite",  PWRITE,  cur_write);
                check("acc_pstrb",   PSTRB,   exp_strb);
                check("acc_pwdata",  PWDATA,  cur_wdata);
                check("acc_buserr",  bus_err, 0);
                for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
                if (k == waits && rd_fix[32]) PRDATA[32*slot +: 32] = rd_fix[31:0];
                if (k == waits) exp_rd = PRDATA[32*slot +: 32];
                rdy  = NS'($urandom);
                rdy[slot] = (k == waits);
                PREADY = rdy;
                serr = NS'($urandom);
                serr[slot] = slverr;
                PSLVERR = serr;
                scramble_req();
            end
            @(posedge HCLK);
            @(negedge HCLK);
        end

        if (err) exp_rd = ERRD;
        else if (cur_write) exp_rd = 32'h0;

        check("resp_hready",  HREADY,  1);
        check("resp_psel",    PSEL,    0);
        check("resp_penable", PENABLE, 0);
        check("resp_hrdata",  HRDATA,  exp_rd);
        check("resp_buserr",  bus_err, err);
        last_hrdata = exp_rd;
        HSEL = 1'b0;
    endtask

    initial begin
        HRESET  = 1'b1;
        HSEL    = 1'b0;
        HADDR   = '0;
        HWRITE  = 1'b0;
        HBE     = '0;
        HWDATA  = '0;
        PRDATA  = '0;
        PREADY  = '0;
        PSLVERR = '0;
        last_hrdata = 32'h0;

        // Reset state.
        repeat (2) @(negedge HCLK);
        check("rst_hrdata",  HRDATA,  0);
        check("rst_hready",  HREADY,  1);
        check("rst_paddr",   PADDR,   0);
        check("rst_psel",    PSEL,    0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite",  PWRITE,  0);
        check("rst_pstrb",   PSTRB,   0);
        check("rst_pwdata",  PWDATA,  0);
        check("rst_buserr",  bus_err, 0);
        HRESET = 1'b0;
        idle_cycles(2);

        // Read, zero wait states, slot 1.
        drive_req(32'h4000E004, 1'b0, 4'hF, 32'h0);
        finish_xfer(0, 1'b0, {1'b1, 32'h12345678});
        idle_cycles(1);

        // Write, two wait states, slot 0; HRDATA returns 0.
        drive_req(32'h4000D008, 1'b1, 4'b0011, 32'hA5A50001);
        finish_xfer(2, 1'b0, '0);

        // Back-to-back decode error at slot index 4.
        drive_req(32'h40011000, 1'b0, 4'hF, 32'h0);
        finish_xfer(0, 1'b0, '0);
        idle_cycles(2);

        // Address just below the region is also a decode error.
        drive_req(32'h4000CFFC, 1'b0, 4'hF, 32'h0);
        finish_xfer(0, 1'b0, '0);
        idle_cycles(1);

        // Timeout: PREADY never rises, PENABLE high for exactly TMO cycles.
        drive_req(32'h4000F010, 1'b0, 4'hF, 32'h0);
        finish_xfer(TMO + 12, 1'b0, '0);
        idle_cycles(1);

        // PREADY in the last allowed cycle completes normally.
        drive_req(32'h4000D100, 1'b0, 4'hF, 32'h0);
        finish_xfer(TMO - 1, 1'b0, {1'b1, 32'hCAFEF00D});
        idle_cycles(1);

        // Slave error on slot 3, then back-to-back read of slot 2.
        drive_req(32'h40010000, 1'b0, 4'hF, 32'h0);
        finish_xfer(1, 1'b1, '0);
        drive_req(32'h4000F000, 1'b0, 4'hF, 32'h0);
        finish_xfer(0, 1'b0, '0);
        idle_cycles(1);

        // Reset while ACCESS waits on PREADY.
        drive_req(32'h4000E000, 1'b0, 4'hF, 32'h0);
        @(posedge HCLK);
        @(negedge HCLK);
        HSEL   = 1'b0;
        PREADY = '0;
        @(posedge HCLK);
        @(negedge HCLK);
        check("pre_rst_penable", PENABLE, 1);
        #2 HRESET = 1'b1;
        #1;
        check("mid_rst_psel",    PSEL,    0);
        check("mid_rst_penable", PENABLE, 0);
        check("mid_rst_hready",  HREADY,  1);
        check("mid_rst_hrdata",  HRDATA,  0);
        last_hrdata = 32'h0;
        @(negedge HCLK);
        HRESET = 1'b0;
        idle_cycles(1);
        drive_req(32'h4000E008, 1'b0, 4'hF, 32'h0);
        finish_xfer(1, 1'b0, '0);
        idle_cycles(1);

        // Randomized transfers.
        repeat (250) begin
            int          r;
            int          w;
            bit          se;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 7)
                a = BASE + 32'($urandom_range(0, NS - 1)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
            else if (r == 7)
                a = BASE + 32'($urandom_range(NS, NS + 2)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
            else if (r == 8)
                a = BASE - 32'($urandom_range(1, 64)) * 32'd4;
            else
                a = $urandom | 32'h80000000;
            w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, TMO - 1);
            se = ($urandom_range(0, 5) == 0);
            drive_req(a, 1'($urandom), 4'($urandom), $urandom);
            finish_xfer(w, se, '0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-side slave 3 of the system bus: the bus selects this block for addresses at or above 0x4000D000, i.e. the UART/peripheral region.
- Converts each selected bus transfer into one APB SETUP/ACCESS transaction.
- Decodes the region into NUM_PSLV 4 KB peripheral slots and drives a per-slot PSEL.
- Returns read data and HREADY to the bus, with decode-error, slave-error and timeout handling.

Parameters:
- ADDR_WIDTH, 32, address width, matches the bus.
- BASE_ADDR, 32'h4000D000, start of the APB region.
- NUM_PSLV, 4, number of APB slots; slot size is 4 KB (index = (HADDR-BASE_ADDR)>>12).
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without PREADY before abort.
- ERR_DATA, 32'hDEADBEEF, HRDATA value returned on any error.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset, asynchronous, active-high
- HSEL  in  1  bridge selected by the bus (address phase)
- HADDR  in  ADDR_WIDTH  transfer address
- HWRITE  in  1  1=write
- HBE  in  4  byte enables
- HWDATA  in  32  write data, valid in the same cycle as HSEL
- HRDATA  out  32  read data to the bus
- HREADY  out  1  transfer complete
- PADDR  out  ADDR_WIDTH  latched HADDR
- PSEL  out  NUM_PSLV  one-hot slot select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB write
- PSTRB  out  4  write strobes
- PWDATA  out  32  write data
- PRDATA  in  NUM_PSLV*32  per-slot read data; slot i occupies [32i+31:32i]
- PREADY  in  NUM_PSLV  per-slot ready
- PSLVERR  in  NUM_PSLV  per-slot error
- bus_err  out  1  one-cycle pulse on any error response

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESET is asynchronous and active-high.
- Reset values: state=IDLE, HRDATA=0, HREADY=1, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PSTRB=0, PWDATA=0, bus_err=0, timeout counter=0.
- Reset mid-transfer: asserting HRESET during SETUP or ACCESS drops PSEL/PENABLE immediately (asynchronously) and abandons the transfer.
- State IDLE: HREADY=1.
  - HSEL=1 with a valid slot (HADDR>=BASE_ADDR and index<NUM_PSLV): latch HADDR, HWRITE, HWDATA, index; PSTRB=HBE if write, else 0; go to SETUP.
  - HSEL=1 with an invalid slot: go to RESP with error; no APB cycle is started.
- State SETUP: exactly one cycle; PSEL[index]=1, PENABLE=0, HREADY=0; go to ACCESS.
- State ACCESS: PSEL[index]=1, PENABLE=1, HREADY=0; PADDR/PWRITE/PSTRB/PWDATA held stable.
  - PREADY[index]=1: capture the response and go to RESP. Read: HRDATA=PRDATA slot index. Write: HRDATA=0. PSLVERR[index]=1 overrides either case to an error.
  - Timeout counter: cleared on entry to ACCESS, increments each ACCESS cycle without PREADY. On reaching TIMEOUT_CYCLES, go to RESP with error and deassert PSEL/PENABLE.
- State RESP: HREADY=1 for one cycle. PSEL=0, PENABLE=0. HRDATA holds the captured value, or ERR_DATA on error. bus_err=1 only in an error RESP.
  - The bus may present a new transfer in this same cycle. HSEL=1 is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- HSEL during SETUP/ACCESS: ignored; the bus cannot issue a new transfer while HREADY=0.
- Latency, transfer accepted at cycle T0: SETUP at T1, ACCESS from T2, HREADY=1 at T(3+wait states). A decode error gives HREADY=1 at T1.
- HRDATA is held between responses; cleared only by reset.
- Simultaneous PREADY and timeout in the same cycle: PREADY wins (normal completion).

Test Plan:
1. Read, zero wait: HADDR=0x4000E004, HSEL=1 at T0, PREADY=4'b1111, PRDATA slot1=0x12345678 -> PSEL=4'b0010 at T1–T2, PENABLE=1 at T2 only, HREADY=1 with HRDATA=0x12345678 at T3, bus_err=0.
2. Write, 2 wait states: HADDR=0x4000D008, HWRITE=1, HBE=4'b0011, HWDATA=0xA5A50001, PREADY[0] high at T4 -> PWRITE=1, PSTRB=4'b0011, PWDATA=0xA5A50001 stable T1–T4; HREADY=1 at T5 with HRDATA=0.
3. Decode error: HADDR=0x40011000 (index 4) -> PSEL stays 0; HREADY=1, HRDATA=0xDEADBEEF, bus_err=1 at T1 only.
4. Timeout, TIMEOUT_CYCLES=8: PREADY held 0 -> PENABLE high exactly 8 cycles, then RESP with HRDATA=0xDEADBEEF, bus_err pulse, PSEL=0.
5. Slave error: read slot 3 (0x40010000), PREADY[3]=1 with PSLVERR[3]=1 -> HRDATA=0xDEADBEEF, bus_err=1. Follow with a back-to-back read (HSEL=1 during RESP) to slot 2 -> SETUP on the next cycle, no IDLE cycle.
6. Reset mid-ACCESS: assert HRESET during PREADY=0 -> PSEL=0, PENABLE=0, HREADY=1 immediately. After release, a fresh read of slot 1 completes normally.
